// File: rtl/serial_subt_ctrl.sv
// ---------------------------------------------------------------------------
// serial_subt_ctrl
//   Bit-serial WIDTH-bit unsigned subtractor controller. A single 1-bit
//   subtract cell (two half-subtractor stages plus a borrow OR) is stepped
//   across the operands LSB first. The borrow is carried between steps in a
//   register. One operation takes WIDTH+2 cycles from accept to next accept.
//
// Ports:
//   i_clk     system clock, all logic on the rising edge
//   i_rst     synchronous reset, active-high
//   i_start   start request, accepted only while o_ready=1
//   i_a       minuend, sampled on the accepting edge only
//   i_b       subtrahend, sampled on the accepting edge only
//   o_ready   high in IDLE
//   o_busy    high in RUN
//   o_done    one-cycle pulse, o_diff/o_borrow valid
//   o_diff    i_a - i_b mod 2^WIDTH, held until the next accepted start
//   o_borrow  1 iff i_a < i_b (unsigned), held until the next accepted start
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// half_subtractor
//   One half-subtractor stage: d = a ^ b, borrow = ~a & b.
// Ports:
//   a_i   minuend bit
//   b_i   subtrahend bit
//   d_o   difference bit
//   br_o  borrow-out bit
// ---------------------------------------------------------------------------
module half_subtractor (
    input  logic a_i,
    input  logic b_i,
    output logic d_o,
    output logic br_o
);
    always_comb begin
        d_o  = a_i ^ b_i;
        br_o = ~a_i & b_i;
    end
endmodule

// ---------------------------------------------------------------------------
// subtract_cell
//   Full 1-bit subtract cell built from two half-subtractor stages.
// Ports:
//   a_i     minuend bit
//   b_i     subtrahend bit
//   bin_i   borrow-in
//   d_o     difference bit
//   bout_o  borrow-out
// ---------------------------------------------------------------------------
module subtract_cell (
    input  logic a_i,
    input  logic b_i,
    input  logic bin_i,
    output logic d_o,
    output logic bout_o
);
    logic d1;
    logic br1;
    logic br2;

    half_subtractor u_stage1 (
        .a_i  (a_i),
        .b_i  (b_i),
        .d_o  (d1),
        .br_o (br1)
    );

    half_subtractor u_stage2 (
        .a_i  (d1),
        .b_i  (bin_i),
        .d_o  (d_o),
        .br_o (br2)
    );

    always_comb begin
        bout_o = br1 | br2;
    end
endmodule

module serial_subt_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_ready,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_diff,
    output logic             o_borrow
);
    // Counter only needs to reach WIDTH-1; keep at least one bit for WIDTH=1.
    localparam int unsigned CW = (WIDTH < 2) ? 1 : $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;
    logic             brw_q;
    logic             brw_d;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] a_d;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] b_d;
    logic [WIDTH-1:0] diff_q;
    logic [WIDTH-1:0] diff_d;
    logic             borrow_q;
    logic             borrow_d;

    logic             cell_d;
    logic             cell_bout;
    logic             last_step;

    subtract_cell u_cell (
        .a_i    (a_q[0]),
        .b_i    (b_q[0]),
        .bin_i  (brw_q),
        .d_o    (cell_d),
        .bout_o (cell_bout)
    );

    always_comb begin
        last_step = (cnt_q == CW'(WIDTH - 1));
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next-state logic ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (i_start) state_d = RUN;
            RUN:     if (last_step) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        o_ready = 1'b0;
        o_busy  = 1'b0;
        o_done  = 1'b0;
        unique case (state_q)
            IDLE:    o_ready = 1'b1;
            RUN:     o_busy  = 1'b1;
            DONE:    o_done  = 1'b1;
            default: o_ready = 1'b0;
        endcase
    end

    // ---------------- Datapath next-state ----------------
    always_comb begin
        cnt_d    = cnt_q;
        brw_d    = brw_q;
        a_d      = a_q;
        b_d      = b_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        unique case (state_q)
            IDLE: begin
                if (i_start) begin
                    a_d      = i_a;
                    b_d      = i_b;
                    cnt_d    = '0;
                    brw_d    = 1'b0;
                    diff_d   = '0;
                    borrow_d = 1'b0;
                end
            end
            RUN: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                brw_d = cell_bout;
                cnt_d = cnt_q + CW'(1);
                // Shift-and-OR form keeps the MSB insert legal for WIDTH=1.
                diff_d = (diff_q >> 1) | (WIDTH'(cell_d) << (WIDTH - 1));
                if (last_step) begin
                    borrow_d = cell_bout;
                end
            end
            default: begin
            end
        endcase
    end

    // ---------------- Datapath registers ----------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q    <= '0;
            brw_q    <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            brw_q    <= brw_d;
            a_q      <= a_d;
            b_q      <= b_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
        end
    end

    always_comb begin
        o_diff   = diff_q;
        o_borrow = borrow_q;
    end
endmodule

// File: tb/tb_serial_subt_ctrl.sv
// ---------------------------------------------------------------------------
// tb_serial_subt_ctrl
//   Directed bench for serial_subt_ctrl with a WIDTH=8 and a WIDTH=1
//   instance sharing clock and reset. Inputs change 1 time unit after a
//   rising edge; outputs are sampled at the same point.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_serial_subt_ctrl;
    logic       clk;
    logic       rst;

    logic       st8;
    logic [7:0] a8;
    logic [7:0] b8;
    logic       rdy8;
    logic       busy8;
    logic       done8;
    logic [7:0] diff8;
    logic       brw8;

    logic       st1;
    logic [0:0] a1;
    logic [0:0] b1;
    logic       rdy1;
    logic       busy1;
    logic       done1;
    logic [0:0] diff1;
    logic       brw1;

    int errors;
    int checks;

    serial_subt_ctrl #(.WIDTH(8)) u_dut8 (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_start  (st8),
        .i_a      (a8),
        .i_b      (b8),
        .o_ready  (rdy8),
        .o_busy   (busy8),
        .o_done   (done8),
        .o_diff   (diff8),
        .o_borrow (brw8)
    );

    serial_subt_ctrl #(.WIDTH(1)) u_dut1 (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_start  (st1),
        .i_a      (a1),
        .i_b      (b1),
        .o_ready  (rdy1),
        .o_busy   (busy1),
        .o_done   (done1),
        .o_diff   (diff1),
        .o_borrow (brw1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        st8 = 1'b0; a8 = '0; b8 = '0;
        st1 = 1'b0; a1 = '0; b1 = '0;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if ({rdy8, busy8, done8, diff8, brw8} !== {3'b100, 8'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset8: rdy=%b busy=%b done=%b diff=%0d brw=%b, want 1 0 0 0 0",
                     rdy8, busy8, done8, diff8, brw8);
        end
        checks++;
        if ({rdy1, busy1, done1, diff1, brw1} !== {3'b100, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset1: rdy=%b busy=%b done=%b diff=%0d brw=%b, want 1 0 0 0 0",
                     rdy1, busy1, done1, diff1, brw1);
        end
        tick();
        checks++;
        if (rdy8 !== 1'b1 || busy8 !== 1'b0) begin
            errors++;
            $display("FAIL idle_hold: rdy=%b busy=%b, want 1 0", rdy8, busy8);
        end
    endtask

    // One WIDTH=8 operation: counts busy cycles, checks result and hold.
    task automatic run_op8(input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] ed, input logic eb, input string nm);
        int n;
        a8 = a; b8 = b; st8 = 1'b1;
        tick();
        st8 = 1'b0;
        a8 = ~a; b8 = ~b;
        n = 0;
        while (done8 !== 1'b1 && n < 40) begin
            if (busy8 !== 1'b1 || rdy8 !== 1'b0) begin
                errors++;
                $display("FAIL %s_busy: cycle %0d busy=%b rdy=%b, want 1 0", nm, n, busy8, rdy8);
            end
            tick();
            n++;
        end
        checks++;
        if (n !== 8) begin
            errors++;
            $display("FAIL %s_latency: busy cycles=%0d, want 8", nm, n);
        end
        checks++;
        if (diff8 !== ed || brw8 !== eb || busy8 !== 1'b0 || rdy8 !== 1'b0) begin
            errors++;
            $display("FAIL %s_result: diff=%0d brw=%b busy=%b rdy=%b, want %0d %b 0 0",
                     nm, diff8, brw8, busy8, rdy8, ed, eb);
        end
        tick();
        tick();
        checks++;
        if (diff8 !== ed || brw8 !== eb || rdy8 !== 1'b1 || done8 !== 1'b0) begin
            errors++;
            $display("FAIL %s_hold: diff=%0d brw=%b rdy=%b done=%b, want %0d %b 1 0",
                     nm, diff8, brw8, rdy8, done8, ed, eb);
        end
    endtask

    task automatic test_subtract();
        run_op8(8'd200, 8'd55, 8'd145, 1'b0, "a200_b55");
        run_op8(8'd55, 8'd200, 8'd111, 1'b1, "a55_b200");
        run_op8(8'd0, 8'd1, 8'd255, 1'b1, "a0_b1");
        run_op8(8'hA5, 8'hA5, 8'd0, 1'b0, "aA5_bA5");
    endtask

    // i_start held high throughout; operands scrambled during RUN.
    task automatic test_back_to_back();
        int n;
        a8 = 8'h3C; b8 = 8'h71; st8 = 1'b1;
        tick();
        checks++;
        if (busy8 !== 1'b1 || diff8 !== 8'd0 || brw8 !== 1'b0) begin
            errors++;
            $display("FAIL b2b_accept_clear: busy=%b diff=%0d brw=%b, want 1 0 0", busy8, diff8, brw8);
        end
        n = 1;
        while (done8 !== 1'b1 && n < 40) begin
            a8 = 8'($urandom); b8 = 8'($urandom);
            tick();
            n++;
        end
        checks++;
        if (n !== 9 || diff8 !== 8'd203 || brw8 !== 1'b1) begin
            errors++;
            $display("FAIL b2b_first: n=%0d diff=%0d brw=%b, want 9 203 1", n, diff8, brw8);
        end
        a8 = 8'h00; b8 = 8'hFF;
        tick();
        checks++;
        if (rdy8 !== 1'b1 || busy8 !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle: rdy=%b busy=%b, want 1 0", rdy8, busy8);
        end
        a8 = 8'hF0; b8 = 8'h0F;
        tick();
        n = 1;
        checks++;
        if (busy8 !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second_accept: busy=%b, want 1", busy8);
        end
        while (done8 !== 1'b1 && n < 40) begin
            a8 = 8'($urandom); b8 = 8'($urandom);
            tick();
            n++;
        end
        st8 = 1'b0;
        checks++;
        if (n !== 9 || diff8 !== 8'd225 || brw8 !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second: n=%0d diff=%0d brw=%b, want 9 225 0", n, diff8, brw8);
        end
        tick();
        tick();
    endtask

    task automatic test_reset_mid_run();
        int n;
        bit saw_done;
        a8 = 8'd99; b8 = 8'd17; st8 = 1'b1;
        tick();
        st8 = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({rdy8, busy8, done8, diff8, brw8} !== {3'b100, 8'd0, 1'b0}) begin
            errors++;
            $display("FAIL midrun_reset: rdy=%b busy=%b done=%b diff=%0d brw=%b, want 1 0 0 0 0",
                     rdy8, busy8, done8, diff8, brw8);
        end
        saw_done = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (done8 === 1'b1) saw_done = 1'b1;
            tick();
        end
        checks++;
        if (saw_done !== 1'b0 || rdy8 !== 1'b1) begin
            errors++;
            $display("FAIL midrun_no_done: saw_done=%b rdy=%b, want 0 1", saw_done, rdy8);
        end
        n = 0;
        run_op8(8'd10, 8'd3, 8'd7, 1'b0, "after_reset");
    endtask

    task automatic run_op1(input logic a, input logic b, input logic ed, input logic eb);
        a1 = a; b1 = b; st1 = 1'b1;
        tick();
        st1 = 1'b0;
        checks++;
        if (busy1 !== 1'b1 || rdy1 !== 1'b0) begin
            errors++;
            $display("FAIL w1_busy_%b%b: busy=%b rdy=%b, want 1 0", a, b, busy1, rdy1);
        end
        tick();
        checks++;
        if (done1 !== 1'b1 || diff1 !== ed || brw1 !== eb) begin
            errors++;
            $display("FAIL w1_result_%b%b: done=%b diff=%b brw=%b, want 1 %b %b",
                     a, b, done1, diff1, brw1, ed, eb);
        end
        tick();
        checks++;
        if (rdy1 !== 1'b1 || done1 !== 1'b0) begin
            errors++;
            $display("FAIL w1_idle_%b%b: rdy=%b done=%b, want 1 0", a, b, rdy1, done1);
        end
    endtask

    task automatic test_width1();
        run_op1(1'b0, 1'b0, 1'b0, 1'b0);
        run_op1(1'b0, 1'b1, 1'b1, 1'b1);
        run_op1(1'b1, 1'b0, 1'b1, 1'b0);
        run_op1(1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_subtract();
        test_back_to_back();
        test_reset_mid_run();
        test_width1();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, want finish before 200000ns");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/serial_subt_ctrl.md
Name: serial_subt_ctrl

Overview:
Bit-serial N-bit subtractor controller. Sequences a single 1-bit subtract cell, built from two half-subtractor stages plus a borrow OR, across WIDTH bits, LSB first, keeping the borrow in a register between cycles. The controller accepts a start request, latches the operands, runs WIDTH bit-steps, then presents the difference and final borrow with a one-cycle done pulse. It sits between a requesting controller and the small half-subtractor datapath, trading latency for area.

Parameters:
WIDTH, 8, operand/result width in bits (legal range 1..32)

Ports:
i_clk  input  1  system clock, all logic on rising edge
i_rst  input  1  synchronous reset, active-high
i_start  input  1  start request; accepted only when o_ready=1
i_a  input  WIDTH  minuend, sampled on the accepting edge only
i_b  input  WIDTH  subtrahend, sampled on the accepting edge only
o_ready  output  1  high in IDLE; operation can be accepted
o_busy  output  1  high in RUN
o_done  output  1  one-cycle pulse; o_diff/o_borrow valid
o_diff  output  WIDTH  result i_a - i_b mod 2^WIDTH
o_borrow  output  1  final borrow; 1 iff i_a < i_b (unsigned)

Behaviour:
- Reset (i_rst=1 at a rising edge): state=IDLE, bit counter=0, borrow reg=0, operand shift regs=0, o_diff=0, o_borrow=0, o_done=0, o_busy=0, o_ready=1. Reset overrides everything, including i_start.
- States: IDLE, RUN, DONE.
- IDLE: o_ready=1. If i_start=1 at edge k, latch i_a/i_b into shift regs, clear the borrow reg and counter, clear o_diff, and go to RUN. Otherwise stay.
- RUN: one bit per edge. Cell inputs are a0 = LSB of a-reg, b0 = LSB of b-reg, and bin = borrow reg.
- Stage 1: d1 = a0^b0, br1 = ~a0&b0.
- Stage 2: d = d1^bin, br2 = ~d1&bin.
- Bit result: bout = br1|br2. d shifts into o_diff from the MSB side (right shift), a/b regs shift right, borrow reg <= bout, counter++.
- After the WIDTH-th bit-step (edge k+WIDTH), go to DONE. o_borrow <= bout of the final step.
- DONE: o_done=1 for exactly one cycle, o_busy=0, o_ready=0. On the next edge, go to IDLE.
- Latency: o_done is high in the cycle after edge k+WIDTH. Next accept is possible at edge k+WIDTH+2. Throughput is one op per WIDTH+2 cycles.
- o_diff and o_borrow hold their values from DONE until the next accepted start. At that accepting edge, o_diff and o_borrow clear to 0.
- i_start is ignored in RUN and DONE; there is no queuing. i_a/i_b changes after the accepting edge have no effect.
- o_ready, o_busy and o_done are mutually exclusive, and exactly one is high at every cycle after reset.
- Reset mid-RUN or in DONE aborts the operation: no o_done pulse, all outputs go to reset values.
- WIDTH=1: RUN lasts exactly one edge, and the result equals a single 1-bit subtract cell.
- Arithmetic is unsigned modulo 2^WIDTH. {o_borrow,o_diff} equals the (WIDTH+1)-bit two's-complement of i_a-i_b.

Test Plan:
- Reset then idle: hold i_rst 2 cycles, release -> o_ready=1, o_busy=0, o_done=0, o_diff=0, o_borrow=0.
- WIDTH=8, i_a=200, i_b=55, pulse i_start -> o_busy for 8 cycles, o_done pulse in cycle 9 after accept, o_diff=145, o_borrow=0. Values hold until next start.
- WIDTH=8, i_a=55, i_b=200 -> o_diff=111, o_borrow=1. Also i_a=0, i_b=1 -> o_diff=255, o_borrow=1. Also i_a=i_b=0xA5 -> o_diff=0, o_borrow=0.
- Hold i_start=1 continuously and change i_a/i_b every cycle during RUN -> result matches the operands latched at the accepting edge. Second op is accepted only at the first IDLE edge, i.e. WIDTH+2 cycles after the first accept.
- Assert i_rst for 1 cycle at bit-step 4 of a RUN -> no o_done pulse, outputs go to reset values, o_ready=1 next cycle. A fresh op afterwards (i_a=10, i_b=3) gives o_diff=7, o_borrow=0.
- WIDTH=1 instance: all four (a,b) combinations -> (diff,borrow) = (0,0)(1,1)(1,0)(0,0) for ab=00,01,10,11, o_done 1 cycle after accept+1.
